// File: rtl/sequence_control_pkg.sv
// Shared definitions for the A09 sequence controller: FSM states, opcodes,
// register-file data-in source encodings and the decoded-opcode bundle.
package sequence_control_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] DIN_ALU = 2'd0;
  localparam logic [1:0] DIN_MEM = 2'd1;
  localparam logic [1:0] DIN_IMM = 2'd2;

  typedef struct packed {
    logic is_alu;
    logic is_ld;
    logic is_st;
    logic is_ldi;
    logic is_brz;
    logic is_halt;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational opcode classifier feeding the sequence controller.
module instruction_decoder
  import sequence_control_pkg::*;
(
  input  logic [3:0] i_opcode,
  output dec_t       o_dec
);

  // Map each opcode onto exactly one instruction class (NOP maps to none).
  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_NOP:                              o_dec = '0;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: o_dec.is_alu  = 1'b1;
      OP_LD:                               o_dec.is_ld   = 1'b1;
      OP_ST:                               o_dec.is_st   = 1'b1;
      OP_LDI:                              o_dec.is_ldi  = 1'b1;
      OP_BRZ:                              o_dec.is_brz  = 1'b1;
      OP_HALT:                             o_dec.is_halt = 1'b1;
      default:                             o_dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sequence_control.sv
// A09 sequence control matrix: multi-cycle fetch/decode/execute/writeback FSM
// driving register-file, ALU, PC and memory-port strobes.
module sequence_control
  import sequence_control_pkg::*;
#(
  parameter int DataWidth  = 16,
  parameter int SelectSize = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic [DataWidth-1:0]  IR_In,
  input  logic                  Mem_Rdy,
  input  logic                  Zero_Flag,
  output logic                  IR_Ld_N,
  output logic                  PC_Inc,
  output logic                  PC_Ld_N,
  output logic                  Mem_Rd_N,
  output logic                  Mem_Wr_N,
  output logic                  Addr_Sel,
  output logic                  REG_WE,
  output logic [SelectSize-1:0] REG_Dst,
  output logic [SelectSize-1:0] REG_Src1,
  output logic [SelectSize-1:0] REG_Src2,
  output logic [1:0]            DIn_Sel,
  output logic [3:0]            ALU_Op,
  output logic                  Halted,
  output logic                  Illegal
);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_op;
  logic [SelectSize-1:0] r_dst;
  logic [SelectSize-1:0] r_src1;
  logic [SelectSize-1:0] r_src2;
  logic                  w_ir_load;
  dec_t                  w_dec;
  // Immediate low bits are consumed by the datapath's sign extender, not here.
  logic                  w_unused_imm;

  assign w_unused_imm = ^IR_In[2:0];
  assign w_ir_load    = (r_state == S_FETCH) && Mem_Rdy;

  instruction_decoder u_decoder (
    .i_opcode (r_op),
    .o_dec    (w_dec)
  );

  // State register; reset forces RESET so all decoded outputs go idle at once.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) r_state <= S_RESET;
    else          r_state <= w_state_next;
  end

  // Instruction field latch, loaded on the fetch cycle that memory completes.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_op   <= '0;
      r_dst  <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
    end else if (w_ir_load) begin
      r_op   <= IR_In[DataWidth-1 -: 4];
      r_dst  <= IR_In[9 +: SelectSize];
      r_src1 <= IR_In[6 +: SelectSize];
      r_src2 <= IR_In[3 +: SelectSize];
    end
  end

  // Next-state and strobe decode; only IR_Ld_N/PC_Inc (and the BRZ PC load)
  // look at live inputs, everything else follows state and latched fields.
  always_comb begin
    w_state_next = r_state;
    IR_Ld_N  = 1'b1;
    PC_Inc   = 1'b0;
    PC_Ld_N  = 1'b1;
    Mem_Rd_N = 1'b1;
    Mem_Wr_N = 1'b1;
    Addr_Sel = 1'b0;
    REG_WE   = 1'b1;
    REG_Dst  = '0;
    REG_Src1 = '0;
    REG_Src2 = '0;
    DIn_Sel  = DIN_ALU;
    ALU_Op   = '0;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    case (r_state)
      S_RESET: w_state_next = S_FETCH;
      S_FETCH: begin
        Mem_Rd_N = 1'b0;
        if (Mem_Rdy) begin
          IR_Ld_N      = 1'b0;
          PC_Inc       = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        REG_Src1     = r_src1;
        REG_Src2     = r_src2;
        ALU_Op       = r_op;
        Illegal      = w_dec.is_illegal;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        REG_Src1 = r_src1;
        REG_Src2 = r_src2;
        ALU_Op   = r_op;
        if (w_dec.is_alu || w_dec.is_ldi)     w_state_next = S_WB;
        else if (w_dec.is_ld || w_dec.is_st)  w_state_next = S_MEM;
        else if (w_dec.is_halt)               w_state_next = S_HALT;
        else                                  w_state_next = S_FETCH;
        if (w_dec.is_brz) PC_Ld_N = ~Zero_Flag;
      end
      S_MEM: begin
        REG_Src1 = r_src1;
        REG_Src2 = r_src2;
        ALU_Op   = r_op;
        Addr_Sel = 1'b1;
        Mem_Rd_N = ~w_dec.is_ld;
        Mem_Wr_N = ~w_dec.is_st;
        if (Mem_Rdy) w_state_next = w_dec.is_ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        REG_Src1     = r_src1;
        REG_Src2     = r_src2;
        ALU_Op       = r_op;
        REG_WE       = 1'b0;
        REG_Dst      = r_dst;
        DIn_Sel      = w_dec.is_ld ? DIN_MEM : (w_dec.is_ldi ? DIN_IMM : DIN_ALU);
        w_state_next = S_FETCH;
      end
      S_HALT:  Halted = 1'b1;
      default: w_state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_sequence_control.sv
// Self-checking bench for sequence_control: each instruction is expanded into
// its expected per-cycle output timeline, which is played and compared.
module tb_sequence_control;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b1;
  logic [15:0] IR_In = '0;
  logic        Mem_Rdy = 1'b0;
  logic        Zero_Flag = 1'b0;
  logic        IR_Ld_N, PC_Inc, PC_Ld_N, Mem_Rd_N, Mem_Wr_N, Addr_Sel, REG_WE;
  logic [2:0]  REG_Dst, REG_Src1, REG_Src2;
  logic [1:0]  DIn_Sel;
  logic [3:0]  ALU_Op;
  logic        Halted, Illegal;

  always #5 Clk = ~Clk;

  sequence_control #(.DataWidth(16), .SelectSize(3)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .IR_In(IR_In), .Mem_Rdy(Mem_Rdy),
    .Zero_Flag(Zero_Flag), .IR_Ld_N(IR_Ld_N), .PC_Inc(PC_Inc),
    .PC_Ld_N(PC_Ld_N), .Mem_Rd_N(Mem_Rd_N), .Mem_Wr_N(Mem_Wr_N),
    .Addr_Sel(Addr_Sel), .REG_WE(REG_WE), .REG_Dst(REG_Dst),
    .REG_Src1(REG_Src1), .REG_Src2(REG_Src2), .DIn_Sel(DIn_Sel),
    .ALU_Op(ALU_Op), .Halted(Halted), .Illegal(Illegal)
  );

  typedef struct packed {
    logic       ir_ld_n, pc_inc, pc_ld_n, mem_rd_n, mem_wr_n, addr_sel, reg_we;
    logic [2:0] dst, src1, src2;
    logic [1:0] din;
    logic [3:0] aluop;
    logic       halted, illegal;
  } out_t;

  typedef struct {
    logic [15:0] ir;
    logic        rdy;
    logic        zf;
    out_t        exp;
  } cyc_t;

  cyc_t        q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          g_rdy_one = 1'b0;
  int          cyc_no, wb_cyc, we_cnt, ill_cnt, wr_cnt, pcld_cnt, halt_cnt;
  out_t        wb_snap;

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.ir_ld_n = 1'b1; o.pc_ld_n = 1'b1; o.mem_rd_n = 1'b1;
    o.mem_wr_n = 1'b1; o.reg_we = 1'b1;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.ir_ld_n = IR_Ld_N; o.pc_inc = PC_Inc; o.pc_ld_n = PC_Ld_N;
    o.mem_rd_n = Mem_Rd_N; o.mem_wr_n = Mem_Wr_N; o.addr_sel = Addr_Sel;
    o.reg_we = REG_WE; o.dst = REG_Dst; o.src1 = REG_Src1; o.src2 = REG_Src2;
    o.din = DIn_Sel; o.aluop = ALU_Op; o.halted = Halted; o.illegal = Illegal;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic rdy, input logic zf, input out_t e);
    cyc_t c;
    c.ir = ir; c.rdy = rdy; c.zf = zf; c.exp = e;
    q.push_back(c);
  endtask

  function automatic logic rnd_rdy();
    return g_rdy_one ? 1'b1 : 1'($urandom);
  endfunction

  // Expected timeline of one instruction, from its class and the chosen waits.
  task automatic add_instr(input logic [15:0] ir, input int fw, input int mw, input logic zf);
    logic [3:0] op;
    out_t e, sel;
    logic z;
    op = ir[15:12];
    for (int i = 0; i < fw; i++) begin
      e = idle(); e.mem_rd_n = 1'b0;
      push(16'($urandom), 1'b0, 1'($urandom), e);
    end
    e = idle(); e.mem_rd_n = 1'b0; e.ir_ld_n = 1'b0; e.pc_inc = 1'b1;
    push(ir, 1'b1, 1'($urandom), e);
    sel = idle(); sel.src1 = ir[8:6]; sel.src2 = ir[5:3]; sel.aluop = op;
    e = sel; e.illegal = (op >= 4'hA && op <= 4'hE);
    push(16'($urandom), rnd_rdy(), 1'($urandom), e);
    z = (op == 4'h9) ? zf : 1'($urandom);
    e = sel; if (op == 4'h9 && z) e.pc_ld_n = 1'b0;
    push(16'($urandom), rnd_rdy(), z, e);
    if (op == 4'h6 || op == 4'h7) begin
      e = sel; e.addr_sel = 1'b1;
      if (op == 4'h6) e.mem_rd_n = 1'b0; else e.mem_wr_n = 1'b0;
      for (int i = 0; i < mw; i++) push(16'($urandom), 1'b0, 1'($urandom), e);
      push(16'($urandom), 1'b1, 1'($urandom), e);
    end
    if ((op >= 4'h1 && op <= 4'h6) || op == 4'h8) begin
      e = sel; e.reg_we = 1'b0; e.dst = ir[11:9];
      e.din = (op == 4'h6) ? 2'd1 : ((op == 4'h8) ? 2'd2 : 2'd0);
      push(16'($urandom), rnd_rdy(), 1'($urandom), e);
    end
    if (op == 4'hF) begin
      e = idle(); e.halted = 1'b1;
      for (int i = 0; i < 20; i++) push(16'($urandom), 1'(i), 1'($urandom), e);
    end
  endtask

  task automatic measure();
    cyc_no = 0; wb_cyc = 0; we_cnt = 0; ill_cnt = 0; wr_cnt = 0;
    pcld_cnt = 0; halt_cnt = 0; wb_snap = '0;
  endtask

  // Play up to n scheduled cycles (n<0: all); called at posedge+1.
  task automatic run_sched(input int n);
    cyc_t c;
    out_t got;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      k++;
      IR_In = c.ir; Mem_Rdy = c.rdy; Zero_Flag = c.zf;
      @(negedge Clk);
      got = dut_out();
      check("cycle", got, c.exp);
      cyc_no++;
      if (!got.reg_we) begin
        we_cnt++;
        if (wb_cyc == 0) begin wb_cyc = cyc_no; wb_snap = got; end
      end
      if (got.illegal)   ill_cnt++;
      if (!got.mem_wr_n) wr_cnt++;
      if (!got.pc_ld_n)  pcld_cnt++;
      if (got.halted)    halt_cnt++;
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    Mem_Rdy = 1'($urandom);
    #3;
    check("async_reset", dut_out(), idle());
    @(posedge Clk);
    #1;
    check("reset_hold", dut_out(), idle());
    Reset_N = 1'b1;
    push(16'($urandom), 1'b1, 1'($urandom), idle());
    run_sched(-1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    #1;
    do_reset();

    g_rdy_one = 1'b1;
    measure(); add_instr(16'h1298, 0, 0, 1'b0); run_sched(-1);
    g_rdy_one = 1'b0;
    check_lit("add_wb_cycle", wb_cyc, 4);
    check_lit("add_we_count", we_cnt, 1);
    check_lit("add_dst", int'(wb_snap.dst), 1);
    check_lit("add_src1", int'(wb_snap.src1), 2);
    check_lit("add_src2", int'(wb_snap.src2), 3);
    check_lit("add_din", int'(wb_snap.din), 0);
    check_lit("add_aluop", int'(wb_snap.aluop), 1);

    measure(); add_instr(16'h6480, 0, 3, 1'b0); run_sched(-1);
    check_lit("ld_wb_cycle", wb_cyc, 8);
    check_lit("ld_din", int'(wb_snap.din), 1);
    check_lit("ld_dst", int'(wb_snap.dst), 2);

    measure(); add_instr(16'h81FF, 1, 0, 1'b0); run_sched(-1);
    check_lit("ldi_din", int'(wb_snap.din), 2);
    check_lit("ldi_dst", int'(wb_snap.dst), 0);

    measure(); add_instr(16'h9080, 0, 0, 1'b1); run_sched(-1);
    check_lit("brz_taken", pcld_cnt, 1);
    measure(); add_instr(16'h9080, 0, 0, 1'b0); run_sched(-1);
    check_lit("brz_not_taken", pcld_cnt, 0);

    measure(); add_instr(16'hB000, 0, 0, 1'b0); run_sched(-1);
    check_lit("illegal_pulses", ill_cnt, 1);
    check_lit("illegal_we", we_cnt, 0);
    check_lit("illegal_wr", wr_cnt, 0);
    measure(); add_instr(16'h3A50, 0, 0, 1'b0); run_sched(-1);
    check_lit("after_illegal_wb", wb_cyc, 4);

    measure(); add_instr(16'h70E8, 0, 2, 1'b0); run_sched(-1);
    check_lit("st_wr_cycles", wr_cnt, 3);

    measure(); add_instr(16'hF000, 0, 0, 1'b0); run_sched(-1);
    check_lit("halt_cycles", halt_cnt, 20);
    do_reset();

    // Abort a store while it waits on memory.
    add_instr(16'h70E8, 0, 6, 1'b0);
    run_sched(5);
    IR_In = q[0].ir; Mem_Rdy = 1'b0; Zero_Flag = q[0].zf;
    #2;
    check("st_wait_before_abort", dut_out(), q[0].exp);
    Reset_N = 1'b0;
    #1;
    check("st_abort", dut_out(), idle());
    q.delete();
    do_reset();
    measure(); add_instr(16'h2A50, 0, 0, 1'b0); run_sched(-1);
    check_lit("post_abort_wb", wb_cyc, 4);

    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      add_instr({op, 12'($urandom)}, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom));
      run_sched(-1);
      if (op == 4'hF) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
